// File: rtl/safecrack_pkg.sv
// safecrack_pkg: shared FSM states, digit type, sizing constants and digit decode helpers.
package safecrack_pkg;
    typedef enum logic [2:0] {IDLE, PRESS, GAP, DECIDE, WAIT_CLEAR, DONE} state_t;
    typedef logic [1:0] digit_t;
    localparam int NUM_DIGITS = 3;
    localparam int NUM_CODES = 64;
    function automatic logic [3:0] digit_btn(input digit_t d);
        return ~(4'b0001 << d);
    endfunction
    function automatic digit_t code_digit(input logic [5:0] c, input digit_t k);
        return k == 2'd0 ? c[5:4] : k == 2'd1 ? c[3:2] : c[1:0];
    endfunction
endpackage

// File: rtl/safecrack_autodialer_if.sv
// safecrack_autodialer_if: start/LED inputs and button/status outputs of the autodialer.
interface safecrack_autodialer_if;
    logic       start;
    logic       led_green;
    logic       led_red;
    logic [3:0] btn_n;
    logic       busy;
    logic       found;
    logic       exhausted;
    logic       error;
    logic [5:0] code;
    logic [6:0] attempts;
    modport master(input start, led_green, led_red,
                   output btn_n, busy, found, exhausted, error, code, attempts);
    modport slave(output start, led_green, led_red,
                  input btn_n, busy, found, exhausted, error, code, attempts);
endinterface

// File: rtl/safecrack_sync.sv
// safecrack_sync: 2-flop synchronizer for asynchronous inputs.
module safecrack_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] m;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, m} <= '0;
        else {q, m} <= {m, d};
endmodule

// File: rtl/safecrack_autodialer.sv
// safecrack_autodialer: brute-forces a 3-digit lock code by pressing buttons and watching LEDs.
module safecrack_autodialer
    import safecrack_pkg::*;
#(
    parameter int CLK_FREQ            = 50_000_000,
    parameter int PRESS_CYCLES        = CLK_FREQ / 20,
    parameter int GAP_CYCLES          = CLK_FREQ * 3 / 4,
    parameter int DECIDE_CYCLES       = CLK_FREQ / 4,
    parameter int LOCK_TIMEOUT_CYCLES = CLK_FREQ * 12
) (
    input logic clk,
    input logic rst,
    safecrack_autodialer_if.master bus
);
    localparam logic [31:0] PRESS_LD   = 32'(PRESS_CYCLES - 1);
    localparam logic [31:0] GAP_LD     = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] DECIDE_LD  = 32'(DECIDE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LD = 32'(LOCK_TIMEOUT_CYCLES - 1);
    state_t      state;
    digit_t      idx;
    logic [31:0] cnt;
    logic        green_ok;
    logic [1:0]  leds;
    safecrack_sync #(.WIDTH(2)) u_sync (
        .clk(clk),
        .rst(rst),
        .d({bus.led_green, bus.led_red}),
        .q(leds)
    );
    wire green = leds[1];
    wire red   = leds[0];
    // idx=3 marks the pre-press gap of a new code; the +1 in GAP wraps it to digit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            cnt           <= '0;
            green_ok      <= 1'b0;
            bus.btn_n     <= 4'hF;
            bus.busy      <= 1'b0;
            bus.found     <= 1'b0;
            bus.exhausted <= 1'b0;
            bus.error     <= 1'b0;
            bus.code      <= '0;
            bus.attempts  <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) begin
                    bus.found     <= 1'b0;
                    bus.exhausted <= 1'b0;
                    bus.error     <= 1'b0;
                    bus.code      <= '0;
                    bus.attempts  <= '0;
                    bus.busy      <= 1'b1;
                    bus.btn_n     <= digit_btn(code_digit(6'd0, 2'd0));
                    idx           <= 2'd0;
                    cnt           <= PRESS_LD;
                    state         <= PRESS;
                end
                PRESS: if (cnt == 0) begin
                    bus.btn_n <= 4'hF;
                    cnt       <= GAP_LD;
                    state     <= GAP;
                end else cnt <= cnt - 1;
                GAP: if (cnt == 0) begin
                    if (idx != digit_t'(NUM_DIGITS - 1)) begin
                        idx       <= idx + 2'd1;
                        bus.btn_n <= digit_btn(code_digit(bus.code, idx + 2'd1));
                        cnt       <= PRESS_LD;
                        state     <= PRESS;
                    end else begin
                        green_ok <= 1'b1;
                        cnt      <= DECIDE_LD;
                        state    <= DECIDE;
                    end
                end else cnt <= cnt - 1;
                DECIDE: if (red) begin
                    cnt   <= TIMEOUT_LD;
                    state <= WAIT_CLEAR;
                end else if (cnt == 0) begin
                    bus.found    <= green_ok & green;
                    bus.error    <= ~(green_ok & green);
                    bus.attempts <= green_ok & green ? bus.attempts + 7'd1 : bus.attempts;
                    bus.busy     <= 1'b0;
                    state        <= DONE;
                end else begin
                    green_ok <= green_ok & green;
                    cnt      <= cnt - 1;
                end
                WAIT_CLEAR: if (!red) begin
                    bus.attempts <= bus.attempts + 7'd1;
                    if (bus.code == 6'(NUM_CODES - 1)) begin
                        bus.exhausted <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= DONE;
                    end else begin
                        bus.code <= bus.code + 6'd1;
                        idx      <= 2'd3;
                        cnt      <= GAP_LD;
                        state    <= GAP;
                    end
                end else if (cnt == 0) begin
                    bus.error <= 1'b1;
                    bus.busy  <= 1'b0;
                    state     <= DONE;
                end else cnt <= cnt - 1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_safecrack_autodialer.sv
// tb_safecrack_autodialer: scaled-timing lock model with a scoreboard checking each finished search.
module tb_safecrack_autodialer;
    typedef struct {
        logic       f;
        logic       x;
        logic       e;
        logic [5:0] c;
        logic [6:0] a;
        int         p0;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst;
    logic       mdl_clr;
    int         mode;
    logic [5:0] secret;
    int         checks, passes, viol;
    exp_t       q[$];
    logic [3:0] prev_btn, pressed;
    logic [5:0] entry;
    logic       green, red, hit, prev_busy;
    int         n, fb, rt, p0;
    safecrack_autodialer_if bus();
    safecrack_autodialer #(
        .PRESS_CYCLES(5),
        .GAP_CYCLES(20),
        .DECIDE_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(400)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    assign bus.led_green = green;
    assign bus.led_red   = red;
    assign pressed = prev_btn & ~bus.btn_n;
    function automatic logic [1:0] dig(input logic [3:0] p);
        return p[3] ? 2'd3 : p[2] ? 2'd2 : p[1] ? 2'd1 : 2'd0;
    endfunction
    wire [5:0] new_entry = {entry[3:0], dig(pressed)};
    // lock: verdict 10 cycles after the third press; red holds 200 cycles (forever in mode 2)
    always @(posedge clk) begin
        if (rst || mdl_clr) begin
            prev_btn <= 4'hF;
            green <= 1'b0;
            red <= 1'b0;
            hit <= 1'b0;
            entry <= '0;
            n <= 0;
            fb <= 0;
            rt <= 0;
            p0 <= 0;
        end else begin
            prev_btn <= bus.btn_n;
            if (|pressed) begin
                green <= 1'b0;
                entry <= new_entry;
                if (pressed[0]) p0 <= p0 + 1;
                if (n == 2) begin
                    n <= 0;
                    fb <= 10;
                    hit <= new_entry == secret;
                end else n <= n + 1;
            end
            if (fb != 0) begin
                fb <= fb - 1;
                if (fb == 1) begin
                    if (mode == 0 && hit) green <= 1'b1;
                    else begin
                        red <= 1'b1;
                        rt <= 200;
                    end
                end
            end
            if (rt != 0) begin
                rt <= rt - 1;
                if (rt == 1 && mode != 2) red <= 1'b0;
            end
        end
    end
    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask
    always @(negedge clk) begin
        if (!rst && ($countones(~bus.btn_n) > 1 || (!bus.busy && bus.btn_n != 4'hF))) viol++;
    end
    initial prev_busy = 1'b0;
    always @(negedge clk) begin
        if (prev_busy && !bus.busy && !rst) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("found", bus.found, e.f);
                chk("exhausted", bus.exhausted, e.x);
                chk("error", bus.error, e.e);
                chk("code", bus.code, e.c);
                chk("attempts", bus.attempts, e.a);
                chk("one_flag", bus.found + bus.exhausted + bus.error, 1);
                if (e.p0 >= 0) chk("press0", p0, e.p0);
            end
        end
        prev_busy = bus.busy;
    end
    task automatic set_lock(input int m, input logic [5:0] s);
        mode = m;
        secret = s;
        mdl_clr = 1'b1;
        @(negedge clk);
        mdl_clr = 1'b0;
    endtask
    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask
    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            chk("done_timeout", 0, 1);
            q.delete();
        end
    endtask
    task automatic wait_for(input logic [5:0] c, input logic [3:0] b, input bit use_b, input string name);
        int i;
        for (i = 0; i < 5000; i++) begin
            if (bus.code == c && (!use_b || bus.btn_n == b)) break;
            @(negedge clk);
        end
        if (i == 5000) chk(name, 0, 1);
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_btn"}, bus.btn_n, 4'hF);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_flags"}, {bus.found, bus.exhausted, bus.error}, 0);
        chk({tag, "_code"}, bus.code, 0);
        chk({tag, "_attempts"}, bus.attempts, 0);
    endtask
    initial begin
        checks = 0;
        passes = 0;
        viol = 0;
        mode = 0;
        secret = '0;
        mdl_clr = 1'b0;
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        set_lock(0, 6'h27);
        q.push_back('{f: 1, x: 0, e: 0, c: 6'h27, a: 7'd40, p0: -1});
        pulse_start();
        wait_for(6'd10, 4'hF, 1'b0, "reach_code10");
        pulse_start();
        chk("busy_start_code", bus.code, 10);
        chk("busy_start_attempts", bus.attempts, 10);
        chk("busy_start_busy", bus.busy, 1);
        wait_done(20000);
        set_lock(0, 6'h00);
        q.push_back('{f: 1, x: 0, e: 0, c: 6'h00, a: 7'd1, p0: 3});
        pulse_start();
        wait_done(2000);
        set_lock(1, 6'h00);
        q.push_back('{f: 0, x: 1, e: 0, c: 6'd63, a: 7'd64, p0: -1});
        pulse_start();
        wait_done(20000);
        set_lock(2, 6'h3F);
        q.push_back('{f: 0, x: 0, e: 1, c: 6'h00, a: 7'd0, p0: -1});
        pulse_start();
        wait_done(2000);
        chk("timeout_busy", bus.busy, 0);
        set_lock(0, 6'h27);
        pulse_start();
        wait_for(6'd5, 4'hD, 1'b1, "reach_code5_press2");
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_zero("midpress_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        set_lock(0, 6'h00);
        q.push_back('{f: 1, x: 0, e: 0, c: 6'h00, a: 7'd1, p0: 3});
        pulse_start();
        chk("restart_code", bus.code, 0);
        chk("restart_btn", bus.btn_n, 4'hE);
        chk("restart_busy", bus.busy, 1);
        wait_done(2000);
        chk("btn_legal", viol, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/safecrack_autodialer.md
SAFECRACK_AUTODIALER -- requirements
Module: safecrack_autodialer

Interface
REQ-001 SHALL have parameter CLK_FREQ, 50_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter PRESS_CYCLES, CLK_FREQ/20, number of cycles a button is held low.
REQ-003 SHALL have parameter GAP_CYCLES, CLK_FREQ*3/4, cycles from release to next press; must exceed the lock's 0.5 s feedback window.
REQ-004 SHALL have parameter DECIDE_CYCLES, CLK_FREQ/4, cycles to observe LEDs after the third gap.
REQ-005 SHALL have parameter LOCK_TIMEOUT_CYCLES, CLK_FREQ*12, maximum cycles to wait for led_red to clear.
REQ-006 clk  in  1  system clock; one clock domain only.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 start  in  1  synchronous pulse; begins a search from code 0.
REQ-009 led_green  in  1  lock's green LED, asynchronous.
REQ-010 led_red  in  1  lock's red LED, asynchronous.
REQ-011 btn_n  out  4  active-low button drives to the lock (KEY0-3).
REQ-012 busy  out  1  search in progress.
REQ-013 found  out  1  correct code found; sticky until next start or reset.
REQ-014 exhausted  out  1  all 64 codes tried without success; sticky.
REQ-015 error  out  1  protocol timeout; sticky.
REQ-016 code  out  6  code currently being tried, or the winning code once found.
REQ-017 attempts  out  7  count of completed attempts, 0..64.

Function
REQ-018 Code encoding: digit k (k=0,1,2) = code[5-2k:4-2k]; digit d drives btn_n[d]=0, all other bits 1.
REQ-019 led_green and led_red SHALL pass through a 2-flop synchronizer; all decisions use the synchronized values.
REQ-020 FSM states: IDLE, PRESS, GAP, DECIDE, WAIT_CLEAR, DONE.
REQ-021 IDLE/DONE: on start, clear found, exhausted, error, code and attempts; set digit index 0; go to PRESS next cycle; busy=1 from that cycle.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 PRESS: drive the digit for exactly PRESS_CYCLES, then release to 4'hF and enter GAP.
REQ-024 GAP: btn_n=4'hF for GAP_CYCLES; then, if digit index<2, increment it and enter PRESS, else enter DECIDE.
REQ-025 DECIDE: if synchronized led_red=1 at any cycle, enter WAIT_CLEAR; if led_green=1 on every one of DECIDE_CYCLES cycles, set found and enter DONE with code held; if neither, set error and enter DONE.
REQ-026 led_red has priority over led_green if both are seen in the same cycle.
REQ-027 WAIT_CLEAR: when led_red=0, increment attempts; if code==63, set exhausted and enter DONE; else increment code, set digit index 0, wait GAP_CYCLES with buttons released, then enter PRESS.
REQ-028 WAIT_CLEAR exceeding LOCK_TIMEOUT_CYCLES SHALL set error and enter DONE.
REQ-029 On success, attempts SHALL also increment, so it equals code+1.
REQ-030 At most one btn_n bit SHALL be low in any cycle; btn_n=4'hF in every state except PRESS.
REQ-031 busy=0 in IDLE and DONE; exactly one of found/exhausted/error is set in DONE.
REQ-032 Timing counters are 32 bits and reload on every state entry; code wrap 63->0 SHALL never occur.

Reset
REQ-033 While rst is asserted: btn_n=4'hF; busy, found, exhausted and error = 0; code and attempts = 0; FSM in IDLE; counters and synchronizers cleared.
REQ-034 Reset asserted mid-press SHALL release all buttons within the same cycle (asynchronous).

Structure
REQ-035 A shared package safecrack_pkg SHALL hold the FSM state enum, the 2-bit digit type, the NUM_DIGITS=3 and NUM_CODES=64 constants, and the digit-to-btn_n decode function.
REQ-036 One sub-module, safecrack_sync (2-flop synchronizer, parameterized width), SHALL be instantiated for the LED inputs.

Verification
REQ-037 The bench SHALL use a behavioural lock model with scaled timing (feedback 10 cycles, lockout 200 cycles) and PRESS=5, GAP=20, DECIDE=8, LOCK_TIMEOUT=400.
REQ-038 Lock code 2-1-3 (code 0x27), start -> found=1, code=0x27, attempts=40, exhausted=0, error=0.
REQ-039 Lock code 0-0-0, start -> found after first attempt, code=0, attempts=1, exactly 3 presses of btn_n[0].
REQ-040 Model that never unlocks, start -> exhausted=1, attempts=64, code=63.
REQ-041 Model holding led_red stuck high -> error=1 after 400 cycles in WAIT_CLEAR, busy=0.
REQ-042 rst pulsed during second PRESS of code 5 -> btn_n=4'hF immediately, all outputs zero; a new start restarts at code 0.
